// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: shared types for the memory port path (sizes, requester ids, FSM)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    // Encoding doubles as the memory block's write-enable code.
    typedef enum logic [1:0] {
        SIZE_NONE = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_WORD = 2'b11
    } size_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    function automatic logic misaligned(input size_e size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SIZE_WORD: bad = (lsb != 2'b00);
            SIZE_HALF: bad = lsb[0];
            SIZE_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_read_align.sv
// ---------------------------------------------------------------------------
// mem_read_align: extracts a byte/half/word lane from a memory word, zero-extended
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_read_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  size_e       size,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {addr, 3'b000};

    always_comb begin
        data = 32'h0000_0000;
        case (size)
            SIZE_BYTE: data = {24'h00_0000, shifted[7:0]};
            SIZE_HALF: data = {16'h0000, shifted[15:0]};
            SIZE_WORD: data = shifted;
            default:   data = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter: round-robin fetch/load-store arbiter for a single-port word memory
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req_valid,
    output logic                     if_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] if_req_addr,
    output logic                     if_rsp_valid,
    output logic [31:0]              if_rsp_data,
    output logic                     if_rsp_err,
    input  logic                     ls_req_valid,
    output logic                     ls_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] ls_req_addr,
    input  logic [1:0]               ls_req_size,
    input  logic                     ls_req_write,
    input  logic [31:0]              ls_req_wdata,
    output logic                     ls_rsp_valid,
    output logic [31:0]              ls_rsp_rdata,
    output logic                     ls_rsp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [1:0]               mem_write_enable,
    output logic [31:0]              mem_write_value,
    input  logic [31:0]              mem_read_value
);

    state_e                   state;
    req_id_e                  last_grant;
    req_id_e                  cap_id;
    logic [ADDRESS_WIDTH-1:0] cap_addr;
    size_e                    cap_size;
    logic                     cap_write;
    logic [31:0]              cap_wdata;
    logic                     cap_err;

    logic                     idle;
    size_e                    req_size;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic                     req_err;
    logic [31:0]              aligned;

    // Under contention the port that did not win last time gets the grant.
    assign idle         = (state == IDLE);
    assign if_req_ready = idle && if_req_valid && (!ls_req_valid || last_grant == REQ_LS);
    assign ls_req_ready = idle && ls_req_valid && (!if_req_valid || last_grant == REQ_IF);

    assign req_size = if_req_ready ? SIZE_WORD : size_e'(ls_req_size);
    assign req_addr = if_req_ready ? if_req_addr : ls_req_addr;
    assign req_err  = misaligned(req_size, req_addr[1:0]);

    assign mem_address      = cap_addr;
    assign mem_write_value  = cap_wdata;
    assign mem_write_enable = (state == ACCESS && cap_write && !cap_err) ? cap_size : SIZE_NONE;

    mem_read_align u_align (
        .word (mem_read_value),
        .addr (cap_addr[1:0]),
        .size (cap_size),
        .data (aligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= REQ_LS;
            cap_id       <= REQ_IF;
            cap_addr     <= '0;
            cap_size     <= SIZE_NONE;
            cap_write    <= 1'b0;
            cap_wdata    <= 32'h0;
            cap_err      <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'h0;
            if_rsp_err   <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= 32'h0;
            ls_rsp_err   <= 1'b0;
        end else begin
            // Responses are single-cycle pulses; idle outputs read as zero.
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'h0;
            if_rsp_err   <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_rdata <= 32'h0;
            ls_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_ready || ls_req_ready) begin
                        cap_id     <= if_req_ready ? REQ_IF : REQ_LS;
                        last_grant <= if_req_ready ? REQ_IF : REQ_LS;
                        cap_addr   <= req_addr;
                        cap_size   <= req_size;
                        cap_write  <= ls_req_ready && ls_req_write;
                        cap_wdata  <= ls_req_ready ? ls_req_wdata : 32'h0;
                        cap_err    <= req_err;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                    if (cap_id == REQ_IF) begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_err   <= cap_err;
                        if_rsp_data  <= cap_err ? 32'h0 : aligned;
                    end else begin
                        ls_rsp_valid <= 1'b1;
                        ls_rsp_err   <= cap_err;
                        ls_rsp_rdata <= (cap_err || cap_write) ? 32'h0 : aligned;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the CPU's two memory requesters (instruction fetch, load/store unit) and the single-ported word memory block.
- Arbitrates round-robin, sequences each access through a two-state machine, drives the memory's address, write-enable code and write data, and returns aligned, zero-extended read data.
- Detects misaligned accesses and answers them with an error response, without touching memory.

Parameters:
- ADDRESS_WIDTH, 10, byte-address width; must match the memory block instance.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request valid; held until if_req_ready.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDRESS_WIDTH  fetch byte address; word access, read only.
- if_rsp_valid  out  1  one-cycle fetch response pulse.
- if_rsp_data  out  32  fetched word.
- if_rsp_err  out  1  fetch was misaligned.
- ls_req_valid  in  1  load/store request valid; held until ls_req_ready.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_req_addr  in  ADDRESS_WIDTH  byte address.
- ls_req_size  in  2  01 byte, 10 half, 11 word; 00 is illegal and is treated as misaligned.
- ls_req_write  in  1  1 = store, 0 = load.
- ls_req_wdata  in  32  store data, right-justified.
- ls_rsp_valid  out  1  one-cycle load/store response pulse.
- ls_rsp_rdata  out  32  load data, zero-extended; 0 for stores.
- ls_rsp_err  out  1  access was misaligned or illegal.
- mem_address  out  ADDRESS_WIDTH  to memory block address.
- mem_write_enable  out  2  to memory block: 00 none, 01 byte, 10 half, 11 word.
- mem_write_value  out  32  to memory block write data, right-justified.
- mem_read_value  in  32  from memory block; combinational function of mem_address.

Behaviour:
- States: IDLE, ACCESS.
- Reset values:
  - state IDLE; last_grant = LS, so the first contended request goes to fetch.
  - All request registers 0; all rsp_valid/rsp_err outputs 0; rsp data 0.
  - mem_address 0; mem_write_enable 00.
- Ready signals:
  - Only asserted in IDLE; ready may depend combinationally on valid.
  - Single valid requester: it is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - At most one ready is high per cycle.
- Handshake cycle N (valid & ready): capture id, addr, size (fetch forces 11), write, wdata, and err; update last_grant; go to ACCESS.
- Misalignment (err = 1) when:
  - size 11 and addr[1:0] != 00;
  - size 10 and addr[0] = 1;
  - size 00.
- ACCESS, cycle N+1:
  - mem_address = captured addr.
  - mem_write_enable = size if write & !err, else 00.
  - mem_write_value = captured wdata.
  - Read result formed from mem_read_value: shift right by 8*addr[1:0], then mask to 8/16/32 bits by size, zero-extended.
  - Result registered at the end of the cycle; state returns to IDLE.
- Cycle N+2: the granted port's rsp_valid = 1 for exactly one cycle, with data/err; the other port's rsp outputs stay 0.
- A new request may handshake in cycle N+2, giving a sustained throughput of one access per 2 cycles. Latency is 2 cycles from handshake to response, fixed for every case including errors.
- No rsp_ready: requesters must accept responses unconditionally.
- Outside ACCESS: mem_write_enable = 00; mem_address holds the last captured address.
- Reset asserted mid-ACCESS: state returns to IDLE immediately, write enable drops to 00 asynchronously, and the pending response is discarded (no rsp_valid after reset).
- A valid deasserted before ready is a protocol violation; the bench asserts it never happens.

Decomposition:
- Shared package mem_pkg holds:
  - access-size enum: SIZE_NONE = 00, SIZE_BYTE = 01, SIZE_HALF = 10, SIZE_WORD = 11, matching the memory block's write-enable encoding;
  - requester-id enum: REQ_IF, REQ_LS;
  - state enum: IDLE, ACCESS.
- One combinational sub-module, mem_read_align: inputs word, addr[1:0], size; output shifted and zero-extended data. It is reused later by the cache path.

Test Plan:
- Store word 0xDEADBEEF at 0x010, then load byte 0x012 -> ls_rsp_rdata = 0x000000AD; load half 0x012 -> 0x0000DEAD; fetch 0x010 -> if_rsp_data = 0xDEADBEEF; each response exactly 2 cycles after its handshake.
- Store byte 0x5A at 0x021 onto a word preloaded with 0x11223344 -> a word load of 0x020 returns 0x11225A44.
- Both valid every cycle for 8 requests -> grants alternate IF, LS, IF, LS…, starting with IF after reset; one response per 2 cycles.
- Word store to 0x013 -> ls_rsp_err = 1, mem_write_enable stays 00 throughout; a word load of 0x010 is unchanged. Fetch from 0x002 -> if_rsp_err = 1.
- Assert reset during the ACCESS cycle of a word store -> no response pulse, state IDLE, mem_write_enable = 00 while reset is high; the next request after reset is served normally.
- Back-to-back: store 0x00000001 to 0x000 followed immediately by a load of 0x000 -> the load returns 0x00000001.
